// File: rtl/morse_sequencer.sv
// Sends the Morse pattern of one letter (A..H) on a single output line.
// All intervals are counted in external timebase ticks; outputs are registered.
module morse_sequencer #(
    parameter int CW         = 3,
    parameter int DOT_TICKS  = 1,
    parameter int DASH_TICKS = 3,
    parameter int GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] letter,
    output logic       led,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        ON   = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CW-1:0] DOT_T  = CW'(DOT_TICKS);
    localparam logic [CW-1:0] DASH_T = CW'(DASH_TICKS);
    localparam logic [CW-1:0] GAP_T  = CW'(GAP_TICKS);
    localparam logic [CW-1:0] LAST_T = CW'(1);

    // Patterns are left-aligned: the symbol being sent is always pat[3], 1 = dash.
    function automatic logic [3:0] pat_of(input logic [2:0] sel);
        logic [3:0] p;
        p = 4'b0000;
        case (sel)
            3'd0:    p = 4'b0100; // A .-
            3'd1:    p = 4'b1000; // B -...
            3'd2:    p = 4'b1010; // C -.-.
            3'd3:    p = 4'b1000; // D -..
            3'd4:    p = 4'b0000; // E .
            3'd5:    p = 4'b0010; // F ..-.
            3'd6:    p = 4'b1100; // G --.
            default: p = 4'b0000; // H ....
        endcase
        return p;
    endfunction

    function automatic logic [2:0] len_of(input logic [2:0] sel);
        logic [2:0] n;
        n = 3'd4;
        case (sel)
            3'd0:    n = 3'd2;
            3'd3:    n = 3'd3;
            3'd4:    n = 3'd1;
            3'd6:    n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    logic [3:0] pat_rom [8];
    logic [2:0] len_rom [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rom
            assign pat_rom[gi] = pat_of(3'(gi));
            assign len_rom[gi] = len_of(3'(gi));
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [3:0]    pat_reg, pat_next;
    logic [2:0]    len_reg, len_next;
    logic [CW-1:0] tcnt_reg, tcnt_next;
    logic          led_reg, busy_reg, done_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            pat_reg   <= '0;
            len_reg   <= '0;
            tcnt_reg  <= '0;
            led_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            tcnt_reg  <= tcnt_next;
            // Outputs decode the next state so they line up with the state they describe.
            led_reg   <= (state_next == ON);
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        len_next   = len_reg;
        tcnt_next  = tcnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pat_next   = pat_rom[letter];
                    len_next   = len_rom[letter];
                    state_next = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    tcnt_next  = pat_reg[3] ? DASH_T : DOT_T;
                    state_next = ON;
                end
            end
            ON: begin
                if (tick) begin
                    if (tcnt_reg != LAST_T) begin
                        tcnt_next = tcnt_reg - LAST_T;
                    end else if (len_reg == 3'd1) begin
                        state_next = DONE;
                    end else begin
                        pat_next   = {pat_reg[2:0], 1'b0};
                        len_next   = len_reg - 3'd1;
                        tcnt_next  = GAP_T;
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (tcnt_reg != LAST_T) begin
                        tcnt_next = tcnt_reg - LAST_T;
                    end else begin
                        tcnt_next  = pat_reg[3] ? DASH_T : DOT_T;
                        state_next = ON;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: per-cycle traces of led/busy/done against
// hand-derived waveforms, with cycle 0 being the cycle in which start is sampled.
module tb_morse_sequencer;

    logic       clk;
    logic       resetn;
    logic       tick;
    logic       start;
    logic [2:0] letter;
    logic       led;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    morse_sequencer #(
        .CW(3), .DOT_TICKS(1), .DASH_TICKS(3), .GAP_TICKS(1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick),
        .start  (start),
        .letter (letter),
        .led    (led),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input int c, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc%0d observed=%b expected=%b", tag, c, obs, expv);
        end
    endtask

    // period 0 = tick tied high; otherwise tick pulses in cycles 2, 2+period, ...
    task automatic run_trace(input string tag, input logic [2:0] let_sel, input int ncyc,
                             input int period, input int restart_cyc, input logic [2:0] restart_let,
                             input logic [63:0] el, input logic [63:0] eb, input logic [63:0] ed);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start  = (c == 0) || (c == restart_cyc);
            letter = (restart_cyc >= 0 && c >= restart_cyc) ? restart_let : let_sel;
            tick   = (period == 0) ? 1'b1 : ((c >= 2) && (c % period == 2));
            check({tag, ".led"},  c, led,  el[c]);
            check({tag, ".busy"}, c, busy, eb[c]);
            check({tag, ".done"}, c, done, ed[c]);
        end
        start = 1'b0;
        $display("run %s letter=%0d: %0d cycles traced", tag, let_sel, ncyc);
    endtask

    initial begin
        resetn = 1'b0;
        tick   = 1'b0;
        start  = 1'b0;
        letter = 3'd0;
        repeat (2) @(negedge clk);
        check("reset.led",  0, led,  1'b0);
        check("reset.busy", 0, busy, 1'b0);
        check("reset.done", 0, done, 1'b0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // T1: A .-
        run_trace("T1_A", 3'd0, 9, 0, -1, 3'd0,
                  mask(2,2) | mask(4,6), mask(1,7), mask(7,7));
        // T2: E ., plus a start in the DONE cycle that must be ignored
        run_trace("T2_E", 3'd4, 6, 0, 3, 3'd4,
                  mask(2,2), mask(1,3), mask(3,3));
        // T3: H ....
        run_trace("T3_H", 3'd7, 11, 0, -1, 3'd0,
                  mask(2,2) | mask(4,4) | mask(6,6) | mask(8,8), mask(1,9), mask(9,9));
        // T4: B -... with a tick every 4 clocks
        run_trace("T4_B", 3'd1, 42, 4, -1, 3'd0,
                  mask(3,14) | mask(19,22) | mask(27,30) | mask(35,38), mask(1,39), mask(39,39));
        // T5: C -.-. with a second start (letter E) while busy
        run_trace("T5_C", 3'd2, 15, 0, 4, 3'd4,
                  mask(2,4) | mask(6,6) | mask(8,10) | mask(12,12), mask(1,13), mask(13,13));

        // T6: G aborted by reset during the second dash
        run_trace("T6_Gpre", 3'd6, 8, 0, -1, 3'd0,
                  mask(2,4) | mask(6,7), mask(1,7), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("abort.led",  0, led,  1'b0);
        check("abort.busy", 0, busy, 1'b0);
        check("abort.done", 0, done, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("post_abort.led",  c, led,  1'b0);
            check("post_abort.busy", c, busy, 1'b0);
            check("post_abort.done", c, done, 1'b0);
        end
        run_trace("T6_G", 3'd6, 13, 0, -1, 3'd0,
                  mask(2,4) | mask(6,8) | mask(10,10), mask(1,11), mask(11,11));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
